mda_hdmi_colour_ctrl: RTL
=========================

// Module: mda_hdmi_colour_ctrl
// PURPOSE
//  Sequencer for the MDA HDMI output stage. Synchronises and debounces the two
//  colour-select switches, then applies a new monochrome colour only at a
//  vertical sync edge. Blanks the output for a set number of frames around each
//  change so that no torn or mixed-colour frame reaches the monitor.
//  Also generates the half-rate pixel strobe that the HDMI port uses for
//  720-wide output. Sits between the switch pins/CRTC and the HDMI port.
// PARAMETERS
//  DEBOUNCE_CYCLES  81285  clocks a synced switch pair must be stable (5 ms @16.257 MHz); >=1
//  BLANK_FRAMES     2      vsync edges the output stays blanked after a change; >=1
//  VSYNC_POL        1      active level of vsync input (1=high, 0=low)
// PORTS
//  clk            in   1  pixel clock (dot clock, 2x HDMI pixel rate)
//  reset          in   1  asynchronous, active-high reset
//  switch2        in   1  raw colour switch A (asynchronous, bouncy)
//  switch3        in   1  raw colour switch B (asynchronous, bouncy)
//  vsync          in   1  CRTC vertical sync, polarity per VSYNC_POL
//  colour_sel     out  2  applied colour {switch2,switch3}: 00 grn 01 yel 10 wht 11 red
//  blank          out  1  1 = HDMI port must force R/G/B/I to 0
//  pix_en         out  1  half-rate pixel strobe, toggles every clk
//  change_pending out  1  1 = debounced selection differs from colour_sel
// BEHAVIOUR
//  Reset (async, all regs): colour_sel=00, blank=0, pix_en=0, change_pending=0,
//   state=IDLE, debounce count=0, stable value=00, vsync history=asserted level.
//  Sync: 2-flop synchroniser per switch. Raw-to-synced latency is 2 clk.
//  Debounce: the counter clears whenever the synced pair differs from the
//   candidate value, and the candidate then takes the new value. Otherwise the
//   counter increments and saturates. When the count reaches DEBOUNCE_CYCLES-1,
//   stable <= candidate on the next edge. Counter width is
//   $clog2(DEBOUNCE_CYCLES+1).
//   A glitch shorter than DEBOUNCE_CYCLES never changes stable.
//  vs_rise = vsync at active level AND previous sample inactive (one clk pulse).
//   Because the history resets to the asserted level, no spurious edge occurs
//   if vsync is already active when reset releases.
//  change_pending = (stable != colour_sel), registered.
//  FSM:
//   IDLE    : stable!=colour_sel -> WAIT_VS. A vs_rise in the same cycle is
//             NOT consumed.
//   WAIT_VS : on vs_rise: colour_sel<=stable, blank<=1, frame_cnt<=0, -> BLANK.
//             If stable returns to colour_sel before the edge, -> IDLE with no
//             blanking.
//   BLANK   : each vs_rise increments frame_cnt. On the vs_rise where
//             frame_cnt==BLANK_FRAMES-1: blank<=0. Then -> WAIT_VS if
//             stable!=colour_sel, else -> IDLE.
//             Switch changes during BLANK only update stable; colour_sel is
//             frozen until exit.
//  colour_sel changes only on a vs_rise cycle. blank rises in that same cycle.
//  pix_en: toggles every clk from 0 after reset, free-running, not affected by
//   the FSM.
//  Reset mid-BLANK or mid-WAIT_VS: immediate return to reset values. Blank
//   drops asynchronously.
// STRUCTURE
//  mda_pkg: colour code localparams (COL_GREEN=2'b00, COL_YELLOW=2'b01,
//   COL_WHITE=2'b10, COL_RED=2'b11) and the FSM state enum (IDLE, WAIT_VS, BLANK).
//  Sub-module mda_switch_debounce (#WIDTH=2, #CYCLES): synchroniser, counter,
//   and stable output. Instantiated once.
//  Top level holds the vsync edge detector, FSM, frame counter and pix_en flop.
// TESTING (DEBOUNCE_CYCLES=8, BLANK_FRAMES=2, VSYNC_POL=1 in bench)
//  1 Reset with vsync=1, release, hold switches 00 -> no vs_rise pulse,
//    colour_sel=00, blank=0 forever, pix_en alternates 0,1,0,...
//  2 Switches 00->10 held, then vsync pulses -> change_pending=1 about 11 clk
//    later; colour_sel=10 and blank=1 on the first vs_rise; blank=0 on the
//    2nd vs_rise after that.
//  3 Switch3 glitch of 5 clk -> stable unchanged, change_pending stays 0,
//    colour_sel=00.
//  4 Switches to 11 during BLANK -> colour_sel holds; after blank clears, FSM
//    goes to WAIT_VS; the next vs_rise sets colour_sel=11 and blank=1 again.
//  5 In WAIT_VS, switches return to 00 before vsync -> state IDLE, blank never
//    asserts, colour_sel=00.
//  6 Assert reset mid-BLANK -> same cycle: blank=0, colour_sel=00, pix_en=0.
//    After release, recovery as in test 1.

Source files
------------

// File: rtl/mda_hdmi_colour_ctrl_pkg.sv
// Shared definitions for the MDA HDMI colour sequencer.
// Colour codes and the colour-change FSM states.
package mda_pkg;

  localparam logic [1:0] COL_GREEN  = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_WHITE  = 2'b10;
  localparam logic [1:0] COL_RED    = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    BLANK   = 2'd2
  } state_t;

  function automatic logic differs(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return a != b;
  endfunction

endpackage

// File: rtl/mda_hdmi_colour_ctrl_if.sv
// Switch/vsync inputs and colour/blank outputs
// of the MDA HDMI colour sequencer.
interface mda_hdmi_colour_ctrl_if;

  logic       switch2;
  logic       switch3;
  logic       vsync;
  logic [1:0] colour_sel;
  logic       blank;
  logic       pix_en;
  logic       change_pending;

  modport master (
    output switch2,
    output switch3,
    output vsync,
    input  colour_sel,
    input  blank,
    input  pix_en,
    input  change_pending
  );

  modport slave (
    input  switch2,
    input  switch3,
    input  vsync,
    output colour_sel,
    output blank,
    output pix_en,
    output change_pending
  );

endinterface

// File: rtl/mda_hdmi_colour_ctrl_debounce.sv
// Two-flop synchroniser plus stability counter
// for a bundle of raw mechanical switches.
module mda_switch_debounce #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any movement restarts the stability window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end else begin
      stable <= cand;
    end
  end

endmodule

// File: rtl/mda_hdmi_colour_ctrl.sv
// Applies debounced colour selections on vsync edges,
// blanking the output across each change.
import mda_pkg::*;

module mda_hdmi_colour_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 81285,
  parameter int unsigned BLANK_FRAMES    = 2,
  parameter bit          VSYNC_POL       = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  mda_hdmi_colour_ctrl_if.slave   bus
);

  localparam int unsigned FW = $clog2(BLANK_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLANK_FRAMES - 1);

  logic [1:0]    stable;
  logic          vs_act;
  logic          vs_prev;
  logic          vs_rise;
  logic          diff;
  logic          f_last;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    colour_q;
  logic [1:0]    colour_d;
  logic          blank_q;
  logic          blank_d;
  logic [FW-1:0] frame_q;
  logic [FW-1:0] frame_d;
  logic          pend_q;
  logic          pix_q;

  mda_switch_debounce #(
    .WIDTH  (2),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw    ({bus.switch2, bus.switch3}),
    .stable (stable)
  );

  // History starts asserted so a held vsync gives no edge
  assign vs_act  = (bus.vsync == VSYNC_POL);
  assign vs_rise = vs_act & ~vs_prev;
  assign diff    = differs(stable, colour_q);
  assign f_last  = (frame_q == F_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev <= 1'b1;
      pend_q  <= 1'b0;
      pix_q   <= 1'b0;
    end else begin
      vs_prev <= vs_act;
      pend_q  <= diff;
      pix_q   <= ~pix_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      colour_q <= COL_GREEN;
      blank_q  <= 1'b0;
      frame_q  <= '0;
    end else begin
      state_q  <= state_d;
      colour_q <= colour_d;
      blank_q  <= blank_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (diff)
          state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (!diff)
          state_d = IDLE;
        else if (vs_rise)
          state_d = BLANK;
      end
      BLANK: begin
        if (vs_rise && f_last)
          state_d = diff ? WAIT_VS : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    colour_d = colour_q;
    blank_d  = blank_q;
    frame_d  = frame_q;
    unique case (state_q)
      IDLE: begin
      end
      WAIT_VS: begin
        if (diff && vs_rise) begin
          colour_d = stable;
          blank_d  = 1'b1;
          frame_d  = '0;
        end
      end
      BLANK: begin
        if (vs_rise) begin
          frame_d = frame_q + 1'b1;
          if (f_last)
            blank_d = 1'b0;
        end
      end
      default: begin
        blank_d = 1'b0;
      end
    endcase
  end

  assign bus.colour_sel     = colour_q;
  assign bus.blank          = blank_q;
  assign bus.pix_en         = pix_q;
  assign bus.change_pending = pend_q;

endmodule
